mem_arbiter: RTL and testbench

- Shares the single-port 16-bit instruction/data memory between two requesters.
- Port A is the processor; it fetches in phase 1 and loads/stores in phase 4.
- Port B is the external loader/debug master, which writes programs and reads back results.
- Grants A by fixed priority, with a starvation guard for B. B can lock the memory for bursts. The block also tracks in-flight reads so each read datum returns to its issuer.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/rd_tag_pipe.sv | 43 ++++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_A    = 2'd1,
      OWN_B    = 2'd2
   } owner_t;

   typedef logic [0:0] arb_state_t;
   localparam arb_state_t ARB    = 1'b0;
   localparam arb_state_t LOCK_B = 1'b1;

   typedef struct packed {
      logic   valid;
      owner_t owner;
   } tag_t;

   localparam tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_NONE};

   localparam int                WAIT_W   = 4;
   localparam logic [WAIT_W-1:0] WAIT_SAT = 4'd15;

endpackage

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - read-ownership tag delay line, decodes per-port rvalid
module rd_tag_pipe
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = 1
)
(
   input  logic clock,
   input  logic reset,
   input  tag_t tag_in,
   output logic a_rvalid,
   output logic b_rvalid
);

   tag_t pipe_q [DEPTH];
   tag_t pipe_d [DEPTH];

   // Shift every stage one step toward the output each cycle.
   always_comb begin
      pipe_d[0] = tag_in;
      for (int i = 1; i < DEPTH; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // Stage registers; reset drops every tag still in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= TAG_NONE;
         end
      end else begin
         pipe_q <= pipe_d;
      end
   end

   // The tag leaving the last stage lines up with the returning memory word.
   always_comb begin
      a_rvalid = pipe_q[DEPTH-1].valid && (pipe_q[DEPTH-1].owner == OWN_A);
      b_rvalid = pipe_q[DEPTH-1].valid && (pipe_q[DEPTH-1].owner == OWN_B);
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter for the shared single-port memory
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW           = 12,
   parameter int DW           = 16,
   parameter int READ_LATENCY = 1,
   parameter int MAX_WAIT     = 4
)
(
   input  logic          clock,
   input  logic          reset,
   input  logic          a_req,
   input  logic          a_rw,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic [DW-1:0] a_rdata,
   output logic          a_rvalid,
   input  logic          b_req,
   input  logic          b_rw,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_gnt,
   output logic [DW-1:0] b_rdata,
   output logic          b_rvalid,
   input  logic          b_lock,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_data,
   output logic          m_rw,
   input  logic [DW-1:0] m_q
);

   arb_state_t        state_q, state_d;
   logic [WAIT_W-1:0] wait_b_q, wait_b_d;
   logic [AW-1:0]     m_addr_q, m_addr_d;
   logic [DW-1:0]     m_data_q, m_data_d;
   logic              m_rw_q, m_rw_d;
   tag_t              tag_q, tag_d;
   logic              b_starved;

   // Grant: A wins by priority unless B has waited too long or holds the lock.
   always_comb begin
      b_starved = b_req && (wait_b_q >= WAIT_W'(MAX_WAIT));
      a_gnt     = 1'b0;
      b_gnt     = 1'b0;
      if (state_q == LOCK_B) begin
         b_gnt = b_req;
      end else begin
         a_gnt = a_req && !b_starved;
         b_gnt = b_req && !a_gnt;
      end
   end

   // Lock is only taken when B wins on its own merits, released when b_lock drops.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB:     if (b_gnt && b_lock) state_d = LOCK_B;
         default: if (!b_lock)         state_d = ARB;
      endcase
   end

   // Count consecutive refused B cycles, saturating so it never wraps.
   always_comb begin
      wait_b_d = wait_b_q;
      if (b_gnt || !b_req) begin
         wait_b_d = '0;
      end else if (wait_b_q != WAIT_SAT) begin
         wait_b_d = wait_b_q + 1'b1;
      end
   end

   // Capture the granted command; the read tag travels beside the command register.
   always_comb begin
      m_addr_d = m_addr_q;
      m_data_d = m_data_q;
      m_rw_d   = 1'b0;
      tag_d    = TAG_NONE;
      if (a_gnt) begin
         m_addr_d = a_addr;
         m_data_d = a_wdata;
         m_rw_d   = a_rw;
         tag_d    = '{valid: !a_rw, owner: OWN_A};
      end else if (b_gnt) begin
         m_addr_d = b_addr;
         m_data_d = b_wdata;
         m_rw_d   = b_rw;
         tag_d    = '{valid: !b_rw, owner: OWN_B};
      end
   end

   // State, wait counter and command registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ARB;
         wait_b_q <= '0;
         m_addr_q <= '0;
         m_data_q <= '0;
         m_rw_q   <= 1'b0;
         tag_q    <= TAG_NONE;
      end else begin
         state_q  <= state_d;
         wait_b_q <= wait_b_d;
         m_addr_q <= m_addr_d;
         m_data_q <= m_data_d;
         m_rw_q   <= m_rw_d;
         tag_q    <= tag_d;
      end
   end

   // tag_q is captured on the same edge as m_addr, so READ_LATENCY further
   // stages bring it out in the cycle the memory presents the data.
   rd_tag_pipe #(
      .DEPTH (READ_LATENCY)
   ) u_rd_tag_pipe (
      .clock    (clock),
      .reset    (reset),
      .tag_in   (tag_q),
      .a_rvalid (a_rvalid),
      .b_rvalid (b_rvalid)
   );

   assign m_addr  = m_addr_q;
   assign m_data  = m_data_q;
   assign m_rw    = m_rw_q;
   assign a_rdata = m_q;
   assign b_rdata = m_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed, table-driven bench for mem_arbiter
module tb_mem_arbiter;

   localparam int AW = 12;
   localparam int DW = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          a_req, a_rw, b_req, b_rw, b_lock;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;

   logic          a_gnt, b_gnt, a_rvalid, b_rvalid, m_rw;
   logic [DW-1:0] a_rdata, b_rdata, m_data, m_q;
   logic [AW-1:0] m_addr;

   logic          a_gnt2, b_gnt2, a_rvalid2, b_rvalid2, m_rw2;
   logic [DW-1:0] a_rdata2, b_rdata2, m_data2, m_q2;
   logic [AW-1:0] m_addr2;

   logic          pre_en;
   logic [AW-1:0] pre_addr;
   logic [DW-1:0] pre_data;

   logic [DW-1:0] mem1 [0:4095];
   logic [DW-1:0] mem2 [0:4095];
   logic [DW-1:0] rd2_q [2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   mem_arbiter u_dut (
      .clock(clock), .reset(reset),
      .a_req(a_req), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
      .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid), .b_lock(b_lock),
      .m_addr(m_addr), .m_data(m_data), .m_rw(m_rw), .m_q(m_q)
   );

   mem_arbiter #(.READ_LATENCY(2)) u_dut2 (
      .clock(clock), .reset(reset),
      .a_req(a_req), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt2), .a_rdata(a_rdata2), .a_rvalid(a_rvalid2),
      .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt2), .b_rdata(b_rdata2), .b_rvalid(b_rvalid2), .b_lock(b_lock),
      .m_addr(m_addr2), .m_data(m_data2), .m_rw(m_rw2), .m_q(m_q2)
   );

   // Memory model, one-edge read latency.
   always @(posedge clock) begin
      if (pre_en) mem1[pre_addr] <= pre_data;
      else if (m_rw) mem1[m_addr] <= m_data;
      m_q <= mem1[m_addr];
   end

   // Memory model, two-edge read latency.
   always @(posedge clock) begin
      if (pre_en) mem2[pre_addr] <= pre_data;
      else if (m_rw2) mem2[m_addr2] <= m_data2;
      rd2_q[0] <= mem2[m_addr2];
      rd2_q[1] <= rd2_q[0];
   end
   assign m_q2 = rd2_q[1];

   typedef struct {
      logic          a_req, a_rw;
      logic [AW-1:0] a_addr;
      logic [DW-1:0] a_wdata;
      logic          b_req, b_rw;
      logic [AW-1:0] b_addr;
      logic [DW-1:0] b_wdata;
      logic          b_lock;
      logic          e_a_gnt, e_b_gnt, e_m_rw;
      logic [AW-1:0] e_m_addr;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic ar, input logic arw, input logic [AW-1:0] aa,
                        input logic [DW-1:0] aw, input logic br, input logic brw,
                        input logic [AW-1:0] ba, input logic [DW-1:0] bw, input logic bl);
      a_req = ar; a_rw = arw; a_addr = aa; a_wdata = aw;
      b_req = br; b_rw = brw; b_addr = ba; b_wdata = bw; b_lock = bl;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
   endtask

   function automatic vec_t mk(input logic ar, input logic arw, input logic [AW-1:0] aa,
                               input logic [DW-1:0] aw, input logic br, input logic brw,
                               input logic [AW-1:0] ba, input logic [DW-1:0] bw,
                               input logic bl, input logic eag, input logic ebg,
                               input logic emrw, input logic [AW-1:0] ema);
      vec_t v;
      v.a_req = ar; v.a_rw = arw; v.a_addr = aa; v.a_wdata = aw;
      v.b_req = br; v.b_rw = brw; v.b_addr = ba; v.b_wdata = bw; v.b_lock = bl;
      v.e_a_gnt = eag; v.e_b_gnt = ebg; v.e_m_rw = emrw; v.e_m_addr = ema;
      return v;
   endfunction

   initial begin
      // Contention: B refused four times, then wins once by starvation override.
      vecs[0]  = mk(1'b1, 1'b0, 12'h030, 16'h0000, 1'b1, 1'b0, 12'h040, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h030);
      vecs[1]  = mk(1'b1, 1'b0, 12'h031, 16'h0000, 1'b1, 1'b0, 12'h040, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h031);
      vecs[2]  = mk(1'b1, 1'b0, 12'h032, 16'h0000, 1'b1, 1'b0, 12'h040, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h032);
      vecs[3]  = mk(1'b1, 1'b0, 12'h033, 16'h0000, 1'b1, 1'b0, 12'h040, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h033);
      vecs[4]  = mk(1'b1, 1'b0, 12'h034, 16'h0000, 1'b1, 1'b0, 12'h040, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h040);
      vecs[5]  = mk(1'b1, 1'b0, 12'h034, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h034);
      // Locked burst: A shut out until the cycle after b_lock falls.
      vecs[6]  = mk(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h100, 16'hAAAA, 1'b1, 1'b0, 1'b1, 1'b1, 12'h100);
      vecs[7]  = mk(1'b1, 1'b0, 12'h100, 16'h0000, 1'b1, 1'b1, 12'h101, 16'hBBBB, 1'b1, 1'b0, 1'b1, 1'b1, 12'h101);
      vecs[8]  = mk(1'b1, 1'b0, 12'h100, 16'h0000, 1'b1, 1'b1, 12'h102, 16'hCCCC, 1'b1, 1'b0, 1'b1, 1'b1, 12'h102);
      vecs[9]  = mk(1'b1, 1'b0, 12'h100, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h102);
      vecs[10] = mk(1'b1, 1'b0, 12'h100, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 12'h100);

      idle();
      pre_en = 1'b1; pre_addr = 12'h010; pre_data = 16'h1234;
      tick();
      pre_addr = 12'h005; pre_data = 16'h5555;
      tick();
      pre_addr = 12'h006; pre_data = 16'h6666;
      tick();
      pre_en = 1'b0;
      reset = 1'b0;
      #1;

      // Reset state
      check("rst_m_addr", m_addr, 12'h000);
      check("rst_m_data", m_data, 16'h0000);
      check("rst_m_rw", m_rw, 1'b0);
      check("rst_a_rvalid", a_rvalid, 1'b0);
      check("rst_b_rvalid", b_rvalid, 1'b0);
      check("rst_gnt_no_req", {a_gnt, b_gnt}, 2'b00);

      // Single A read
      drive(1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
      #1;
      check("rd_a_gnt", {a_gnt, b_gnt}, 2'b10);
      tick();
      idle();
      check("rd_m_addr", m_addr, 12'h010);
      check("rd_m_rw", m_rw, 1'b0);
      check("rd_early_rvalid", a_rvalid, 1'b0);
      tick();
      check("rd_a_rvalid", a_rvalid, 1'b1);
      check("rd_a_rdata", a_rdata, 16'h1234);
      check("rd_b_rvalid", b_rvalid, 1'b0);
      tick();
      check("rd_rvalid_one_cycle", a_rvalid, 1'b0);

      // Table: contention and locked burst
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].a_req, vecs[i].a_rw, vecs[i].a_addr, vecs[i].a_wdata,
               vecs[i].b_req, vecs[i].b_rw, vecs[i].b_addr, vecs[i].b_wdata, vecs[i].b_lock);
         #1;
         check($sformatf("vec%0d_a_gnt", i), a_gnt, vecs[i].e_a_gnt);
         check($sformatf("vec%0d_b_gnt", i), b_gnt, vecs[i].e_b_gnt);
         tick();
         check($sformatf("vec%0d_m_rw", i), m_rw, vecs[i].e_m_rw);
         check($sformatf("vec%0d_m_addr", i), m_addr, vecs[i].e_m_addr);
      end
      idle();
      tick();
      tick();

      // Read back the burst with back-to-back A reads
      drive(1'b1, 1'b0, 12'h100, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
      tick();
      drive(1'b1, 1'b0, 12'h101, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
      tick();
      check("burst_rv0", a_rvalid, 1'b1);
      check("burst_rd0", a_rdata, 16'hAAAA);
      drive(1'b1, 1'b0, 12'h102, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
      tick();
      check("burst_rv1", a_rvalid, 1'b1);
      check("burst_rd1", a_rdata, 16'hBBBB);
      idle();
      tick();
      check("burst_rv2", a_rvalid, 1'b1);
      check("burst_rd2", a_rdata, 16'hCCCC);
      tick();

      // Write then read same address
      drive(1'b1, 1'b1, 12'h020, 16'h0FFF, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
      #1;
      check("wr_a_gnt", a_gnt, 1'b1);
      tick();
      check("wr_m_rw", m_rw, 1'b1);
      check("wr_m_data", m_data, 16'h0FFF);
      drive(1'b1, 1'b0, 12'h020, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
      tick();
      check("wr_m_rw_single", m_rw, 1'b0);
      check("wr_no_rvalid", a_rvalid, 1'b0);
      idle();
      tick();
      check("raw_rvalid", a_rvalid, 1'b1);
      check("raw_rdata", a_rdata, 16'h0FFF);
      tick();

      // Lock request while A is granted is deferred
      drive(1'b1, 1'b0, 12'h050, 16'h0000, 1'b1, 1'b0, 12'h060, 16'h0000, 1'b1);
      #1;
      check("defer_gnt0", {a_gnt, b_gnt}, 2'b10);
      tick();
      drive(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h060, 16'h0000, 1'b1);
      #1;
      check("defer_gnt1", {a_gnt, b_gnt}, 2'b01);
      tick();
      drive(1'b1, 1'b0, 12'h051, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1);
      #1;
      check("locked_a_gnt", a_gnt, 1'b0);
      tick();
      b_lock = 1'b0;
      #1;
      check("unlock_edge_a_gnt", a_gnt, 1'b0);
      tick();
      #1;
      check("unlocked_a_gnt", a_gnt, 1'b1);
      tick();
      idle();
      tick();
      tick();

      // Interleaved reads with two-edge latency
      drive(1'b1, 1'b0, 12'h005, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
      tick();
      drive(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h006, 16'h0000, 1'b0);
      #1;
      check("il_b_gnt", b_gnt2, 1'b1);
      tick();
      idle();
      check("il_rv_early", {a_rvalid2, b_rvalid2}, 2'b00);
      tick();
      check("il_rv_a", {a_rvalid2, b_rvalid2}, 2'b10);
      check("il_rd_a", a_rdata2, 16'h5555);
      tick();
      check("il_rv_b", {a_rvalid2, b_rvalid2}, 2'b01);
      check("il_rd_b", b_rdata2, 16'h6666);
      tick();
      check("il_rv_done", {a_rvalid2, b_rvalid2}, 2'b00);

      // Reset one cycle after a read accept
      drive(1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
      tick();
      idle();
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_m_addr", m_addr, 12'h000);
      check("mid_rst_m_rw", m_rw, 1'b0);
      tick();
      check("mid_rst_rv0", {a_rvalid, b_rvalid}, 2'b00);
      reset = 1'b0;
      tick();
      check("mid_rst_rv1", {a_rvalid, b_rvalid}, 2'b00);
      tick();
      check("mid_rst_rv2", {a_rvalid, b_rvalid}, 2'b00);
      drive(1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
      #1;
      check("post_rst_a_gnt", a_gnt, 1'b1);
      tick();
      idle();
      check("post_rst_m_addr", m_addr, 12'h010);
      tick();
      check("post_rst_rvalid", a_rvalid, 1'b1);
      check("post_rst_rdata", a_rdata, 16'h1234);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
